// File: rtl/xor4_arbiter.sv
// Two-requester arbiter feeding an external 4-bit XOR datapath.
// One transaction in flight: accept, execute, then hold the result until taken.
module xor4_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   output logic       req1_ready,
   output logic [3:0] xor_a,
   output logic [3:0] xor_b,
   input  logic [3:0] xor_y,
   output logic       res_valid,
   output logic [3:0] res_y,
   output logic       res_id,
   input  logic       res_ready,
   output logic       busy,
   output logic [7:0] txn_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t     state_q, state_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic [3:0] y_q, y_d;
   logic       vld_q, vld_d;
   logic       id_q, id_d;
   logic       last_q, last_d;
   logic [7:0] cnt_q, cnt_d;
   logic       gnt1;
   logic       accept;
   logic       done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Round-robin favours whoever did not win last; fixed mode favours req0.
   always_comb begin
      gnt1 = req1_valid && (!req0_valid || (RR_EN && !last_q));
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!rst && state_q == IDLE) begin
         req1_ready = gnt1;
         req0_ready = req0_valid && !gnt1;
      end
      accept = req0_ready || req1_ready;
      done   = (state_q == RESP) && vld_q && res_ready;
      busy   = (state_q != IDLE);
   end

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      y_d    = y_q;
      vld_d  = vld_q;
      id_d   = id_q;
      last_d = last_q;
      cnt_d  = cnt_q;
      if (accept) begin
         a_d    = req1_ready ? req1_a : req0_a;
         b_d    = req1_ready ? req1_b : req0_b;
         id_d   = req1_ready;
         last_d = req1_ready;
      end
      if (state_q == EXEC) begin
         y_d   = xor_y;
         vld_d = 1'b1;
      end
      if (done) begin
         vld_d = 1'b0;
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         y_q    <= '0;
         vld_q  <= 1'b0;
         id_q   <= 1'b0;
         last_q <= 1'b1;
         cnt_q  <= '0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         y_q    <= y_d;
         vld_q  <= vld_d;
         id_q   <= id_d;
         last_q <= last_d;
         cnt_q  <= cnt_d;
      end
   end

   assign xor_a     = a_q;
   assign xor_b     = b_q;
   assign res_valid = vld_q;
   assign res_y     = y_q;
   assign res_id    = id_q;
   assign txn_count = cnt_q;

endmodule

// File: tb/tb_xor4_arbiter.sv
// Directed bench for xor4_arbiter: per-cycle reference model plus a
// result scoreboard; a fixed-priority instance shares the same stimulus.
module tb_xor4_arbiter;

   typedef struct packed {
      logic       id;
      logic [3:0] y;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       r0v, r1v, res_ready;
   logic [3:0] r0a, r0b, r1a, r1b;

   logic       r0r, r1r, res_valid, res_id, busy;
   logic [3:0] xor_a, xor_b, xor_y, res_y;
   logic [7:0] txn_count;

   logic       fp_r0r, fp_r1r, fp_res_valid, fp_res_id, fp_busy;
   logic [3:0] fp_xor_a, fp_xor_b, fp_xor_y, fp_res_y;
   logic [7:0] fp_txn_count;

   int         n_chk;
   int         n_pass;
   bit         fp_on;
   int         m_state;
   logic       m_last;
   logic [7:0] m_cnt;
   logic [3:0] m_a, m_b;
   exp_t       sb[$];

   always #5 clk = ~clk;

   assign xor_y    = xor_a ^ xor_b;
   assign fp_xor_y = fp_xor_a ^ fp_xor_b;

   xor4_arbiter #(.RR_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(r0v), .req0_a(r0a), .req0_b(r0b), .req0_ready(r0r),
      .req1_valid(r1v), .req1_a(r1a), .req1_b(r1b), .req1_ready(r1r),
      .xor_a(xor_a), .xor_b(xor_b), .xor_y(xor_y),
      .res_valid(res_valid), .res_y(res_y), .res_id(res_id),
      .res_ready(res_ready), .busy(busy), .txn_count(txn_count)
   );

   xor4_arbiter #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst(rst),
      .req0_valid(r0v), .req0_a(r0a), .req0_b(r0b), .req0_ready(fp_r0r),
      .req1_valid(r1v), .req1_a(r1a), .req1_b(r1b), .req1_ready(fp_r1r),
      .xor_a(fp_xor_a), .xor_b(fp_xor_b), .xor_y(fp_xor_y),
      .res_valid(fp_res_valid), .res_y(fp_res_y), .res_id(fp_res_id),
      .res_ready(res_ready), .busy(fp_busy), .txn_count(fp_txn_count)
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp_v);
      n_chk++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
   endtask

   // One clock: check outputs at the falling edge, then advance the model.
   task automatic cyc();
      logic e0, e1;
      exp_t e;
      @(negedge clk);
      if (rst) begin
         m_state = 0;
         m_last  = 1'b1;
         m_cnt   = '0;
         m_a     = '0;
         m_b     = '0;
         sb.delete();
      end
      e0 = 1'b0;
      e1 = 1'b0;
      if (!rst && m_state == 0) begin
         if (r1v && (!r0v || !m_last)) e1 = 1'b1;
         else if (r0v) e0 = 1'b1;
      end
      chk("req0_ready", 8'(r0r), 8'(e0));
      chk("req1_ready", 8'(r1r), 8'(e1));
      chk("busy", 8'(busy), 8'(m_state != 0));
      chk("res_valid", 8'(res_valid), 8'(m_state == 2));
      chk("txn_count", txn_count, m_cnt);
      chk("xor_a", 8'(xor_a), 8'(m_a));
      chk("xor_b", 8'(xor_b), 8'(m_b));
      if (rst) begin
         chk("rst_res_y", 8'(res_y), 8'h00);
         chk("rst_res_id", 8'(res_id), 8'h00);
         chk("rst_fp_ready", 8'(fp_r0r | fp_r1r), 8'h00);
      end
      if (m_state == 2 && sb.size() > 0) begin
         chk("res_y", 8'(res_y), 8'(sb[0].y));
         chk("res_id", 8'(res_id), 8'(sb[0].id));
      end
      if (fp_on) begin
         chk("fp_req1_ready", 8'(fp_r1r), 8'h00);
         if (fp_res_valid) begin
            chk("fp_res_id", 8'(fp_res_id), 8'h00);
            chk("fp_res_y", 8'(fp_res_y), 8'h01);
         end
      end
      if (!rst) begin
         case (m_state)
            0: if (e0 || e1) begin
               e.id  = e1;
               e.y   = e1 ? (r1a ^ r1b) : (r0a ^ r0b);
               m_a   = e1 ? r1a : r0a;
               m_b   = e1 ? r1b : r0b;
               sb.push_back(e);
               m_last  = e1;
               m_state = 1;
            end
            1: m_state = 2;
            2: if (res_ready) begin
               e = sb.pop_front();
               m_cnt++;
               m_state = 0;
            end
            default: m_state = 0;
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk   = 0;
      n_pass  = 0;
      fp_on   = 1'b0;
      m_state = 0;
      m_last  = 1'b1;
      m_cnt   = '0;
      m_a     = '0;
      m_b     = '0;
      rst     = 1'b1;
      r0v = 1'b1; r1v = 1'b0; res_ready = 1'b0;
      r0a = 4'h3; r0b = 4'h6; r1a = 4'h0; r1b = 4'h0;
      cyc();
      cyc();
      rst = 1'b0;
      r0v = 1'b0;
      cyc();

      // Single request from req0; operands change after acceptance.
      r0a = 4'b0100; r0b = 4'b1100; r0v = 1'b1; res_ready = 1'b1;
      cyc();
      r0v = 1'b0; r0a = 4'hf; r0b = 4'h0;
      repeat (4) cyc();

      // Tie from fresh reset: round-robin alternates, fixed always req0.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      r0a = 4'b1001; r0b = 4'b1000; r1a = 4'b0101; r1b = 4'b1010;
      r0v = 1'b1; r1v = 1'b1; fp_on = 1'b1;
      repeat (9) cyc();
      fp_on = 1'b0;
      r0v = 1'b0; r1v = 1'b0;
      cyc();

      // Backpressure with req1 waiting throughout.
      r0a = 4'h3; r0b = 4'h5; r0v = 1'b1; res_ready = 1'b0;
      cyc();
      r0v = 1'b0; r1v = 1'b1; r1a = 4'hc; r1b = 4'h6;
      cyc();
      repeat (6) cyc();
      res_ready = 1'b1;
      cyc();
      r1v = 1'b0;
      repeat (4) cyc();

      // Reset during EXEC aborts; next tie goes to req0.
      r0a = 4'h7; r0b = 4'h1; r0v = 1'b1;
      cyc();
      r0v = 1'b0;
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      repeat (4) cyc();
      r0a = 4'h2; r0b = 4'h8; r1a = 4'h9; r1b = 4'h4;
      r0v = 1'b1; r1v = 1'b1;
      cyc();
      r0v = 1'b0; r1v = 1'b0;
      repeat (3) cyc();

      // Enough back-to-back transactions to wrap txn_count.
      r0a = 4'ha; r0b = 4'h3; r0v = 1'b1;
      repeat (256 * 3) cyc();
      r0v = 1'b0;
      repeat (3) cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
